// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between core stores and the pito_uart transmitter.
// A drain FSM hands one byte at a time to the UART. It waits for the busy
// handshake to go high and then low again before it sends the next byte.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   wr_en        core store to the TX data address, one byte per cycle
//   wr_data      byte to transmit
//   clr_ovf      clears the sticky overflow flag
//   uart_busy    busy from the transmitter
//   uart_wr      one-cycle write strobe to the transmitter
//   uart_tx_data byte presented with uart_wr
//   full/empty   occupancy flags
//   count        occupied entries
//   status       core-readable status word
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | nothing in flight; strobe the head byte when UART is free
// WAIT_HI | byte strobed; waiting for uart_busy to rise (with timeout)
// WAIT_LO | transmitter busy; waiting for uart_busy to fall
module uart_tx_fifo #(
   parameter int DEPTH        = 16,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [7:0]             wr_data,
   input  logic                   clr_ovf,
   input  logic                   uart_busy,
   output logic                   uart_wr,
   output logic [7:0]             uart_tx_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [31:0]            status
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_HI = 2'd1,
      WAIT_LO = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          overflow;
   logic [TW-1:0] tmr;
   logic          pop;
   logic          push;
   logic          drop;
   logic          tx_busy;

   always_comb begin
      full    = (count == CW'(DEPTH));
      empty   = (count == '0);
      pop     = (state == IDLE) && !empty && !uart_busy;
      // A full FIFO still accepts a byte when the head leaves on the same edge.
      push    = wr_en && (!full || pop);
      drop    = wr_en && full && !pop;
      tx_busy = !empty || (state != IDLE);
      status  = {16'h0000, 8'(count), 4'h0, overflow, empty, full, tx_busy};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pop) state_nxt = WAIT_HI;
         end
         WAIT_HI: begin
            if (uart_busy)       state_nxt = WAIT_LO;
            else if (tmr == '0)  state_nxt = IDLE;
         end
         WAIT_LO: begin
            if (!uart_busy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Down-counter for the lost-handshake timeout. It is loaded so that
   // terminal count is reached on the last allowed cycle in WAIT_HI.
   always_ff @(posedge clk) begin
      if (!rst_n)
         tmr <= '0;
      else if (pop)
         tmr <= TW'(BUSY_TIMEOUT - 1);
      else if ((state == WAIT_HI) && (tmr != '0))
         tmr <= tmr - TW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         overflow     <= 1'b0;
         uart_wr      <= 1'b0;
         uart_tx_data <= 8'h00;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // A dropped byte wins over a clear in the same cycle.
         if (drop)         overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
         uart_wr <= pop;
         // Track the head while no strobe is showing, and freeze while strobing.
         // On a pop edge this captures the byte that leaves the FIFO.
         if (!uart_wr) uart_tx_data <= mem[rd_ptr];
      end
   end

endmodule
